// File: rtl/serial_frame_pkg.sv
// Shared types and line-level constants for the serial frame transmitter and its
// matching receiver.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int unsigned clamp_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/bit_period_counter.sv
// Counts clocks within one serial bit period; bit_end marks the last clock of the period.
// The counter restarts on clear or after bit_end.
module bit_period_counter
    import serial_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk_signal,
    input  logic reset_signal,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CNT_W = clamp_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign bit_end = (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear || bit_end) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_signal or posedge reset_signal) begin
        if (reset_signal) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// The line output is registered and idles high.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic                  clk_signal,
    input  logic                  reset_signal,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic                  valid_input,
    output logic                  ready_output,
    output logic                  serial_output,
    output logic                  busy_output,
    output logic                  done_output
);

    localparam int unsigned IDX_W = clamp_width(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  parity_q, parity_d;
    logic                  serial_q, serial_d;
    logic                  done_q, done_d;
    logic                  bit_end;

    // Counter is held at zero while idle so START always gets a full bit period.
    bit_period_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_period_counter (
        .clk_signal  (clk_signal),
        .reset_signal(reset_signal),
        .clear       (state_q == IDLE),
        .bit_end     (bit_end)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_input) begin
                    state_d  = START;
                    shift_d  = data_input;
                    parity_d = ^data_input;
                    idx_d    = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line value is chosen from the next state so it changes on the same edge.
        case (state_d)
            START:   serial_d = START_BIT;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = parity_d;
            STOP:    serial_d = STOP_BIT;
            default: serial_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk_signal or posedge reset_signal) begin
        if (reset_signal) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            serial_q <= LINE_IDLE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign ready_output  = (state_q == IDLE);
    assign busy_output   = (state_q != IDLE);
    assign serial_output = serial_q;
    assign done_output   = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench: per-cycle expected {serial, busy, done} entries are queued from a frame
// model when stimulus is driven and compared against the DUT on each falling edge.
module tb_serial_frame_tx;

    logic       clk_signal;
    logic       reset_signal;
    logic [7:0] data_input, data1;
    logic       valid_input, valid1;
    logic       ready_output, serial_output, busy_output, done_output;
    logic       ready1, serial1, busy1, done1;

    logic [2:0] exp_q[$];
    int         errors;
    int         checks;

    serial_frame_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(4),
        .PARITY_EN   (1)
    ) dut (
        .clk_signal   (clk_signal),
        .reset_signal (reset_signal),
        .data_input   (data_input),
        .valid_input  (valid_input),
        .ready_output (ready_output),
        .serial_output(serial_output),
        .busy_output  (busy_output),
        .done_output  (done_output)
    );

    serial_frame_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(1),
        .PARITY_EN   (0)
    ) dut_fast (
        .clk_signal   (clk_signal),
        .reset_signal (reset_signal),
        .data_input   (data1),
        .valid_input  (valid1),
        .ready_output (ready1),
        .serial_output(serial1),
        .busy_output  (busy1),
        .done_output  (done1)
    );

    initial clk_signal = 1'b0;
    always #5 clk_signal = ~clk_signal;

    // Frame model: each bit held cpb cycles with busy high, then one done cycle.
    task automatic push_frame(input logic [7:0] d, input int cpb, input bit par_en);
        logic bits[$];
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(d[b]);
        if (par_en) bits.push_back(^d);
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < cpb; c++) exp_q.push_back({bits[k], 1'b1, 1'b0});
        end
        exp_q.push_back(3'b101);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(3'b100);
    endtask

    task automatic test_reset();
        logic [3:0] got;
        #2;
        got = {serial_output, busy_output, done_output, ready_output};
        checks++;
        if (got !== 4'b1001) begin
            errors++;
            $display("FAIL reset_state: got s/b/d/r=%b required 1001", got);
        end
        got = {serial1, busy1, done1, ready1};
        checks++;
        if (got !== 4'b1001) begin
            errors++;
            $display("FAIL reset_state_fast: got s/b/d/r=%b required 1001", got);
        end
        @(negedge clk_signal);
        reset_signal = 1'b0;
    endtask

    task automatic test_idle();
        logic [2:0] e;
        logic [3:0] got;
        int i = 0;
        valid_input = 1'b0;
        push_idle(20);
        while (exp_q.size() > 0) begin
            @(negedge clk_signal);
            e = exp_q.pop_front();
            got = {serial_output, busy_output, done_output, ready_output};
            checks++;
            if (got !== {e, ~e[1]}) begin
                errors++;
                $display("FAIL idle cycle %0d: got s/b/d/r=%b required %b", i, got, {e, ~e[1]});
            end
            i++;
        end
    endtask

    task automatic test_single_frame(input logic [7:0] d);
        logic [2:0] e;
        logic [3:0] got;
        int i = 0;
        data_input  = d;
        valid_input = 1'b1;
        push_frame(d, 4, 1'b1);
        push_idle(1);
        while (exp_q.size() > 0) begin
            @(negedge clk_signal);
            e = exp_q.pop_front();
            got = {serial_output, busy_output, done_output, ready_output};
            checks++;
            if (got !== {e, ~e[1]}) begin
                errors++;
                $display("FAIL frame_%h cycle %0d: got s/b/d/r=%b required %b",
                         d, i, got, {e, ~e[1]});
            end
            valid_input = 1'b0;
            data_input  = 8'($urandom);
            i++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        logic [3:0] got;
        int i = 0;
        data_input  = 8'h00;
        valid_input = 1'b1;
        push_frame(8'h00, 4, 1'b1);
        push_frame(8'hFF, 4, 1'b1);
        push_idle(1);
        while (exp_q.size() > 0) begin
            @(negedge clk_signal);
            e = exp_q.pop_front();
            got = {serial_output, busy_output, done_output, ready_output};
            checks++;
            if (got !== {e, ~e[1]}) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got s/b/d/r=%b required %b",
                         i, got, {e, ~e[1]});
            end
            if (i == 0) data_input = 8'hFF;
            if (i == 45) valid_input = 1'b0;
            i++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] e;
        logic [3:0] got;
        int i = 0;
        data_input  = 8'h3C;
        valid_input = 1'b1;
        push_frame(8'h3C, 4, 1'b1);
        // Cycles 13..16 carry data bit 2; stop after checking cycle 14.
        while (i < 14) begin
            @(negedge clk_signal);
            e = exp_q.pop_front();
            got = {serial_output, busy_output, done_output, ready_output};
            checks++;
            if (got !== {e, ~e[1]}) begin
                errors++;
                $display("FAIL pre_reset_3c cycle %0d: got s/b/d/r=%b required %b",
                         i, got, {e, ~e[1]});
            end
            valid_input = 1'b0;
            i++;
        end
        exp_q.delete();
        #2 reset_signal = 1'b1;
        #1;
        got = {serial_output, busy_output, done_output, ready_output};
        checks++;
        if (got !== 4'b1001) begin
            errors++;
            $display("FAIL reset_mid_frame: got s/b/d/r=%b required 1001", got);
        end
        @(negedge clk_signal);
        got = {serial_output, busy_output, done_output, ready_output};
        checks++;
        if (got !== 4'b1001) begin
            errors++;
            $display("FAIL reset_held: got s/b/d/r=%b required 1001", got);
        end
        reset_signal = 1'b0;
        data_input   = 8'h5A;
        valid_input  = 1'b1;
        push_frame(8'h5A, 4, 1'b1);
        push_idle(2);
        i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk_signal);
            e = exp_q.pop_front();
            got = {serial_output, busy_output, done_output, ready_output};
            checks++;
            if (got !== {e, ~e[1]}) begin
                errors++;
                $display("FAIL post_reset_5a cycle %0d: got s/b/d/r=%b required %b",
                         i, got, {e, ~e[1]});
            end
            valid_input = 1'b0;
            i++;
        end
    endtask

    task automatic test_fast_no_parity();
        logic [2:0] e;
        logic [3:0] got;
        int i = 0;
        data1  = 8'h81;
        valid1 = 1'b1;
        push_frame(8'h81, 1, 1'b0);
        push_idle(3);
        while (exp_q.size() > 0) begin
            @(negedge clk_signal);
            e = exp_q.pop_front();
            got = {serial1, busy1, done1, ready1};
            checks++;
            if (got !== {e, ~e[1]}) begin
                errors++;
                $display("FAIL fast_81 cycle %0d: got s/b/d/r=%b required %b",
                         i, got, {e, ~e[1]});
            end
            // Random valid pulses only while the frame is in flight.
            valid1 = e[1] ? 1'($urandom_range(0, 1)) : 1'b0;
            data1  = 8'($urandom);
            i++;
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset_signal = 1'b1;
        valid_input  = 1'b0;
        data_input   = 8'h00;
        valid1       = 1'b0;
        data1        = 8'h00;
        test_reset();
        test_idle();
        test_single_frame(8'hA5);
        test_single_frame(8'h01);
        test_back_to_back();
        test_reset_mid_frame();
        test_fast_no_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Serial frame transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on a single line.
Frame: start bit (0), DATA_WIDTH data bits LSB first, optional even-parity bit, stop bit (1); each bit is held for CLKS_PER_BIT clocks.
Driving end of the team's flip-flop-based serial capture path; the line idles high.

Parameters:
DATA_WIDTH, 8, payload bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each bit is held on serial_output (>=1)
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit

Ports:
clk_signal  input  1  clock, all state updates on rising edge
reset_signal  input  1  reset, asynchronous, active-high
data_input  input  DATA_WIDTH  word to transmit, sampled on acceptance edge
valid_input  input  1  data_input holds a word to send
ready_output  output  1  transmitter can accept a word this cycle
serial_output  output  1  serial line, registered, idle high
busy_output  output  1  frame in progress (start through stop)
done_output  output  1  one-cycle pulse after a frame's stop bit completes

Behaviour:
- Reset (asynchronous, immediate): state IDLE, serial_output=1, ready_output=1, busy_output=0, done_output=0, shift register and counters cleared.
- States:
  - IDLE -> START on acceptance
  - START -> DATA after CLKS_PER_BIT cycles
  - DATA -> PARITY (PARITY_EN=1) or STOP (PARITY_EN=0) after DATA_WIDTH bit periods
  - PARITY -> STOP after one bit period
  - STOP -> IDLE after one bit period
- ready_output=1 only in IDLE; busy_output=1 in START/DATA/PARITY/STOP.
- Acceptance: valid_input && ready_output at a rising edge.
  - data_input is latched into the shift register.
  - Parity is computed as the XOR of all data bits and latched.
  - Next cycle: serial_output=0 (start bit) and busy_output=1.
- Bit timing:
  - A bit-period counter counts 0..CLKS_PER_BIT-1 and resets at each bit boundary.
  - The bit index counts 0..DATA_WIDTH-1 in DATA.
  - The shift register shifts right at each data-bit boundary; serial_output = shift_reg[0] during DATA.
- Frame length: (DATA_WIDTH + PARITY_EN + 2) * CLKS_PER_BIT cycles of busy.
- done_output: 1 for exactly the first IDLE cycle after STOP; serial_output stays 1.
- Back-to-back: a word can be accepted in that same first IDLE cycle, giving a minimum idle gap of 1 cycle (line high).
- Changes on valid_input or data_input while busy are ignored; no queueing.
- valid_input low in IDLE: remain IDLE, line high, no done.
- Reset asserted mid-frame: frame abandoned, line high immediately, no done pulse. The first acceptance is possible in the first clock after reset deasserts.
- CLKS_PER_BIT=1: every bit lasts exactly 1 cycle; the counter width is clamped to a minimum of 1 bit.

Decomposition:
- Package serial_frame_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1
- Sub-module bit_period_counter:
  - parameter CLKS_PER_BIT; inputs clk_signal, reset_signal, clear; output bit_end pulse when count == CLKS_PER_BIT-1.
  - Reused later by the matching receiver.

Test Plan:
All with DATA_WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=1 unless stated.
1. After reset, hold valid_input=0 for 20 cycles -> serial_output=1, ready=1, busy=0, done=0 throughout.
2. Send 0xA5 -> line bits 0|1,0,1,0,0,1,0,1|0|1, each held 4 cycles, 44 busy cycles; done pulses in cycle 45 after acceptance, ready=1 there.
3. Send 0x01 -> parity bit 1; frame 0|1,0,0,0,0,0,0,0|1|1.
4. Send 0x00 with valid held high, 0xFF queued -> 0xFF accepted in the done cycle; exactly 1 idle-high cycle between the 0x00 stop bit and the 0xFF start bit; both parity bits 0.
5. Assert reset_signal during the 3rd data bit of 0x3C -> serial_output=1 and busy=0 immediately; no done; next send of 0x5A is transmitted correctly.
6. Instance with CLKS_PER_BIT=1, PARITY_EN=0, send 0x81 -> 10-cycle frame 0|1,0,0,0,0,0,0,1|1; done on cycle 11; valid pulses during the frame are ignored.
